// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package rv_fetch_pkg;

  localparam int              XLEN         = 32;
  localparam logic [XLEN-1:0] PC_INC       = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } fetch_state_e;

  // Fetches are always whole words; low address bits are forced to zero.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with synchronous clear and occupancy output.
// Used both for the decode-side instruction buffer and the pc-tag queue.
module fetch_fifo #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 2,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [OW-1:0]     occ
);

  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (occ != '0);
  assign do_push = push && ((occ != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + OW'(do_push) - OW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited imem requests,
// in-order response tagging, and stale-response draining after redirects.
module if_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = OW + 1;

  fetch_state_e state, state_n;
  logic [31:0]  fetch_pc, fetch_pc_n;
  logic [OW-1:0] outst, outst_n;
  logic [OW-1:0] drop, drop_n;

  logic [OW-1:0] inst_occ;
  logic [OW-1:0] tag_occ;
  logic [31:0]   tag_pc;
  logic [63:0]   inst_head;

  logic credit;
  logic resp_ok;
  logic acc;
  logic flush;
  logic tag_push;
  logic tag_pop;
  logic inst_push;
  logic req_valid;

  // Credits come from registered counts only, so a pop frees a slot one cycle later.
  assign credit  = ({1'b0, inst_occ} + {1'b0, outst}) < CW'(DEPTH);
  assign resp_ok = i_imem_resp_valid && (outst != '0);
  assign acc     = req_valid && i_imem_req_ready;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    outst_n    = outst;
    drop_n     = drop;
    req_valid  = 1'b0;
    flush      = 1'b0;
    tag_push   = 1'b0;
    tag_pop    = 1'b0;
    inst_push  = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH, S_DRAIN: begin
        if (i_redirect) begin
          // Everything still in flight becomes stale, including nothing arriving now.
          flush      = 1'b1;
          fetch_pc_n = word_align(i_redirect_pc);
          outst_n    = outst - OW'(resp_ok);
          drop_n     = outst_n;
          state_n    = (outst_n != '0) ? S_DRAIN : S_FETCH;
        end else if (state == S_FETCH) begin
          req_valid = credit;
          if (acc) begin
            tag_push   = 1'b1;
            fetch_pc_n = fetch_pc + PC_INC;
          end
          if (resp_ok) begin
            tag_pop   = 1'b1;
            inst_push = (tag_occ != '0);
          end
          outst_n = outst + OW'(acc) - OW'(resp_ok);
        end else begin
          if (resp_ok && (drop != '0)) begin
            outst_n = outst - OW'(1);
            drop_n  = drop - OW'(1);
            state_n = (drop_n == '0) ? S_FETCH : S_DRAIN;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      outst    <= outst_n;
      drop     <= drop_n;
    end
  end

  fetch_fifo #(
    .DATA_W(32),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clr  (flush),
    .push (tag_push),
    .wdata(fetch_pc),
    .pop  (tag_pop),
    .rdata(tag_pc),
    .occ  (tag_occ)
  );

  fetch_fifo #(
    .DATA_W(64),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clr  (flush),
    .push (inst_push),
    .wdata({tag_pc, i_imem_rdata}),
    .pop  (i_inst_ready),
    .rdata(inst_head),
    .occ  (inst_occ)
  );

  assign o_imem_req_valid = req_valid;
  assign o_imem_addr      = fetch_pc;
  assign o_inst_valid     = (inst_occ != '0);
  assign o_inst           = o_inst_valid ? inst_head[31:0]  : 32'h0;
  assign o_inst_pc        = o_inst_valid ? inst_head[63:32] : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a transaction-level model built
// from queues of in-flight fetches (with stale marks) and buffered instructions.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] imem_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req_valid (req_valid),
    .o_imem_addr      (imem_addr),
    .i_imem_req_ready (req_ready),
    .i_imem_resp_valid(resp_valid),
    .i_imem_rdata     (resp_data),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc),
    .o_inst_valid     (inst_valid),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .i_inst_ready     (inst_ready)
  );

  typedef struct {logic [31:0] pc; bit stale;} flight_t;
  typedef struct {logic [31:0] pc; logic [31:0] word;} entry_t;

  flight_t     fq[$];
  entry_t      iq[$];
  logic [31:0] imem_q[$];
  logic [31:0] m_pc;
  bit          m_idle;
  bit          chk_en;

  int checks;
  int errors;
  int cyc;
  int first_req, first_inst, acc_cnt, low_cnt;
  logic [31:0] first_inst_pc;
  logic        last_req, last_ivalid;
  logic [31:0] last_addr, last_inst, last_ipc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit stale_any();
    foreach (fq[i]) if (fq[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit rst, input bit r, input logic [31:0] rpc,
                      input bit rr, input bit ir, input int rmode);
    bit          rv;
    bit          ev;
    logic [31:0] rd;
    flight_t     f;
    entry_t      e;
    rv = 1'b0;
    rd = $urandom;
    if (imem_q.size() > 0 && (rmode == 1 || (rmode == 2 && $urandom_range(0, 2) != 0))) begin
      rv = 1'b1;
      rd = memfn(imem_q.pop_front());
    end else if (imem_q.size() == 0 && rmode == 2 && $urandom_range(0, 40) == 0) begin
      rv = 1'b1;
    end
    rst_n       = !rst;
    redirect    = r;
    redirect_pc = rpc;
    req_ready   = rr;
    inst_ready  = ir;
    resp_valid  = rv;
    resp_data   = rd;
    #1;
    ev = !m_idle && !stale_any() && (iq.size() + fq.size() < DEPTH) && !r;
    last_req    = req_valid;
    last_addr   = imem_addr;
    last_ivalid = inst_valid;
    last_inst   = inst;
    last_ipc    = inst_pc;
    if (chk_en) begin
      check("req_valid", {31'b0, req_valid}, {31'b0, ev});
      check("imem_addr", imem_addr, m_pc);
      check("inst_valid", {31'b0, inst_valid}, (iq.size() > 0) ? 32'd1 : 32'd0);
      check("inst", inst, (iq.size() > 0) ? iq[0].word : 32'h0);
      check("inst_pc", inst_pc, (iq.size() > 0) ? iq[0].pc : 32'h0);
    end
    if (req_valid === 1'b1 && first_req < 0) first_req = cyc;
    if (inst_valid === 1'b1 && first_inst < 0) begin
      first_inst    = cyc;
      first_inst_pc = inst_pc;
    end
    if (inst_valid === 1'b1 && inst_pc < 32'h100) low_cnt++;
    if (req_valid === 1'b1 && rr && !rst) begin
      acc_cnt++;
      imem_q.push_back(imem_addr);
    end
    if (rst) begin
      fq.delete();
      iq.delete();
      imem_q.delete();
      m_pc   = 32'h0;
      m_idle = 1'b1;
      chk_en = 1'b1;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (r) begin
      if (rv && fq.size() > 0) void'(fq.pop_front());
      foreach (fq[i]) fq[i].stale = 1'b1;
      iq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (ir && iq.size() > 0) void'(iq.pop_front());
      if (rv && fq.size() > 0) begin
        f = fq.pop_front();
        if (!f.stale) begin
          e.pc   = f.pc;
          e.word = memfn(f.pc);
          iq.push_back(e);
        end
      end
      if (ev && rr) begin
        f.pc    = m_pc;
        f.stale = 1'b0;
        fq.push_back(f);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    cyc        = 0;
    first_req  = -1;
    first_inst = -1;
    acc_cnt    = 0;
    low_cnt    = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    m_idle = 1'b1;
    m_pc   = 32'h0;
    cyc    = 0;
    first_req = -1;
    first_inst = -1;

    // Streaming from reset with ready imem and decode
    do_reset();
    check("rst_req_valid", {31'b0, last_req}, 32'd0);
    check("rst_inst_valid", {31'b0, last_ivalid}, 32'd0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("first_req_cycle", first_req, 32'd1);
    check("first_inst_cycle", first_inst, 32'd3);
    check("first_inst_pc", first_inst_pc, 32'h0);

    // Decode stalled: credits cap outstanding work at DEPTH
    do_reset();
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    check("accepted_full", acc_cnt, DEPTH);
    check("hold_req_valid", {31'b0, last_req}, 32'd0);
    check("head_pc0", last_ipc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("pop_cycle_req", {31'b0, last_req}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    check("head_pc1", last_ipc, 32'h4);
    check("req_after_pop", {31'b0, last_req}, 32'd1);
    check("addr_after_pop", last_addr, 32'h8);

    // Redirect with two requests outstanding
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 0);
    first_inst = -1;
    low_cnt    = 0;
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("stale_insts", low_cnt, 32'd0);
    check("pc_after_redirect", first_inst_pc, 32'h100);

    // Redirect coinciding with a response and a pop, target not word aligned
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 32'h203, 1'b1, 1'b1, 1);
    check("pre_redir_inst_valid", {31'b0, last_ivalid}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    check("redir_inst_valid", {31'b0, last_ivalid}, 32'd0);
    check("redir_addr", last_addr, 32'h200);
    check("redir_req_valid", {31'b0, last_req}, 32'd1);

    // Redirect to the top word; next fetch wraps to zero
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    check("top_addr", last_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    check("wrap_addr", last_addr, 32'h0);

    // Reset while draining stale responses
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    check("drain_req_valid", {31'b0, last_req}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    check("rst_drain_req", {31'b0, last_req}, 32'd0);
    check("rst_drain_addr", last_addr, 32'h0);
    check("rst_drain_ivalid", {31'b0, last_ivalid}, 32'd0);
    check("rst_drain_inst", last_inst, 32'h0);
    check("rst_drain_ipc", last_ipc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    check("post_rst_req", {31'b0, last_req}, 32'd1);

    // Randomized traffic with occasional resets, redirects and spurious responses
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 11) == 0, rpc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the RISC-V core. It holds the program counter, issues word requests to instruction memory over a valid/ready handshake, buffers returned instructions with their PCs in a small FIFO toward decode, and accepts taken-branch redirects resolved in EX (branch target plus taken decision from zero/negative). It discards in-flight, stale responses after a redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- DEPTH, 2, instruction FIFO entries and maximum outstanding requests; power of two, ≥2
- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- o_imem_req_valid  out  1  fetch request valid
- o_imem_addr  out  32  word address of request; bits [1:0] always 0
- i_imem_req_ready  in  1  imem accepts request this cycle
- i_imem_resp_valid  in  1  response data valid; responses return in request order
- i_imem_rdata  in  32  instruction word
- i_redirect  in  1  taken branch/jump from EX
- i_redirect_pc  in  32  redirect target (EX branch adder output)
- o_inst_valid  out  1  decode-side entry valid
- o_inst  out  32  instruction at FIFO head
- o_inst_pc  out  32  PC of o_inst
- i_inst_ready  in  1  decode consumes head this cycle

## Operation
- FSM states:
  - S_IDLE: entered on reset; issues no request; moves to S_FETCH after one cycle.
  - S_FETCH: normal issue.
  - S_DRAIN: discarding stale responses.
- Counters: `occ` (FIFO occupancy, 0..DEPTH), `outst` (accepted, unreturned requests, 0..DEPTH), `drop` (responses to discard).
- Request issue (S_FETCH only): o_imem_req_valid = (occ + outst < DEPTH) && !i_redirect.
- Request acceptance (valid && ready):
  - Push fetch_pc into the pc-tag queue.
  - fetch_pc += 4, wrapping modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
  - outst++.
- Response (i_imem_resp_valid), when drop = 0 and no redirect this cycle:
  - Pop the pc tag.
  - Write {tag, rdata} into the FIFO; occ++, outst--.
- Pop: o_inst_valid && i_inst_ready → occ--.
- Redirect (highest priority, any state except S_IDLE):
  - FIFO cleared (occ = 0) and pc-tag queue cleared.
  - fetch_pc = {i_redirect_pc[31:2], 2'b00}.
  - drop = outst minus any response arriving this cycle; the arriving response is discarded.
  - outst is reduced by the same arriving response.
  - Next state: S_DRAIN if drop > 0, else S_FETCH.
- S_DRAIN:
  - Each response decrements drop and outst; no FIFO write and no request.
  - Goes to S_FETCH in the cycle drop reaches 0.
  - A further redirect in S_DRAIN reloads fetch_pc; drop keeps counting the remaining outst.
- An unaccepted request may be withdrawn by a redirect. Imem tolerates valid falling without ready.
- A response with outst = 0 is a protocol error. It is ignored and counters do not underflow.

## Timing
- Reset values:
  - o_imem_req_valid = 0, o_imem_addr = RESET_PC.
  - o_inst_valid = 0, o_inst = 0, o_inst_pc = 0.
  - occ = outst = drop = 0, state S_IDLE.
- o_imem_addr = fetch_pc is registered. It is stable while o_imem_req_valid is high and not accepted, unless a redirect occurs.
- Minimum response latency: 1 cycle after acceptance. Responses arriving in the acceptance cycle are not supported.
- FIFO is registered with no bypass. A response written in cycle N appears as o_inst_valid in cycle N+1.
- Credits use registered counts. A pop in cycle N frees issue credit only in cycle N+1.
- FIFO behaviour:
  - Simultaneous push and pop at full is legal; occ unchanged.
  - Pop when empty is ignored.
  - No push when full is possible, by credit rule.
- A redirect in cycle N: o_inst_valid = 0 in N+1. The first request from the target is no earlier than N+1.
- Reset asserted mid-operation: all state returns to reset values at the next edge. Outstanding responses are not tracked; imem is reset together with this block.

## Structure
- Package rv_fetch_pkg: state enum (S_IDLE, S_FETCH, S_DRAIN), PC_INC = 4, default RESET_PC, XLEN = 32.
- Sub-module fetch_fifo: synchronous DEPTH×64 FIFO ({pc, inst}) with clear input, pointer wrap via log2(DEPTH) bits, and occ output.
- The pc-tag queue reuses fetch_fifo at 32-bit width, or is a shared instance parameterised by width.

## Test plan
- Reset release, ready = 1, responses at latency 1, i_inst_ready = 1:
  - Requests at 0x0, 0x4, 0x8… with the first o_imem_req_valid in cycle 1.
  - First o_inst_valid in cycle 3 with o_inst_pc = 0x0.
- i_inst_ready = 0 held: exactly DEPTH = 2 requests are accepted, then o_imem_req_valid stays 0.
  - FIFO shows PCs 0x0, then 0x4 after one pop.
  - A new request appears the cycle after the pop.
- Redirect to 0x100 with 2 requests outstanding:
  - Both responses are dropped, and no o_inst_valid occurs for their PCs.
  - The next o_inst_pc is 0x100.
- Redirect coinciding with a response and a pop:
  - That response is discarded, the FIFO ends empty, and drop = outst - 1.
- Redirect to 0x203: o_imem_addr = 0x200.
- Redirect to 0xFFFF_FFFC: the fetch after it goes to 0x0000_0000.
- Reset asserted while in S_DRAIN: next cycle shows every output at its reset value and the state is S_IDLE.
